// File: rtl/trng_key_arbiter.sv
// rtl/trng_key_arbiter.sv - round-robin arbiter sharing one TRNG key generator among N_REQ consumers
module trng_key_arbiter #(
    parameter int N_REQ          = 4,
    parameter int N_BITS_KEY     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_i,
    output logic [N_REQ-1:0]      gnt_o,
    output logic [N_REQ-1:0]      valid_o,
    output logic [N_BITS_KEY-1:0] key_o,
    output logic                  timeout_o,
    output logic                  fail_o,
    input  logic                  clear_fail_i,
    output logic                  trng_enable_o,
    output logic                  trng_ack_read_o,
    input  logic                  trng_key_ready_i,
    input  logic [N_BITS_KEY-1:0] trng_key_i,
    input  logic                  trng_intr_i
);

    localparam int LW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_DELIVER,
        S_DRAIN,
        S_FAIL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [N_REQ-1:0]      r_gnt;
    logic [LW-1:0]         r_last;
    logic [CW-1:0]         r_cnt;
    logic [N_BITS_KEY-1:0] r_key;
    logic                  r_timeout;

    logic                  w_enable;
    logic                  w_ack;
    logic                  w_timeout_hit;
    logic                  w_found;
    logic [LW-1:0]         w_idx;
    logic [LW-1:0]         w_win_idx;
    logic [N_REQ-1:0]      w_win_oh;

    // Round-robin search starting just after the last winner, with wrap-around.
    always_comb begin
        w_found   = 1'b0;
        w_idx     = '0;
        w_win_idx = '0;
        w_win_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = LW'((int'(r_last) + 1 + i) % N_REQ);
            if (!w_found && req_i[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
        w_win_oh[w_win_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enable      = 1'b0;
        w_ack         = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_i) w_state_nxt = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                w_enable = 1'b1;
                if (trng_key_ready_i) begin
                    w_ack       = 1'b1;
                    w_state_nxt = (|(req_i & r_gnt)) ? S_DELIVER : S_DRAIN;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES))) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_DELIVER: begin
                w_enable    = 1'b1;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_enable = 1'b1;
                if (!trng_key_ready_i) w_state_nxt = S_IDLE;
            end
            S_FAIL: begin
                if (clear_fail_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A total-failure interrupt overrides capture and timeout in the same cycle.
        if (trng_intr_i) begin
            w_state_nxt   = S_FAIL;
            w_ack         = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_last    <= LW'(N_REQ - 1);
            r_cnt     <= '0;
            r_key     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= w_timeout_hit;
            if (trng_intr_i) begin
                r_gnt <= '0;
                r_key <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (|req_i) begin
                            r_gnt  <= w_win_oh;
                            r_last <= w_win_idx;
                            r_cnt  <= '0;
                        end
                    end
                    S_WAIT_KEY: begin
                        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                        if (trng_key_ready_i) begin
                            if (|(req_i & r_gnt)) r_key <= trng_key_i;
                            else                  r_gnt <= '0;
                        end else if (w_timeout_hit) begin
                            r_gnt <= '0;
                        end
                    end
                    S_DELIVER: begin
                        r_gnt <= '0;
                        r_key <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign gnt_o           = r_gnt;
    assign valid_o         = (r_state == S_DELIVER) ? r_gnt : '0;
    assign key_o           = (r_state == S_DELIVER) ? r_key : '0;
    assign timeout_o       = r_timeout;
    assign fail_o          = (r_state == S_FAIL);
    assign trng_enable_o   = w_enable;
    assign trng_ack_read_o = w_ack;

endmodule

// File: doc/trng_key_arbiter.md
# trng_key_arbiter

Round-robin arbiter that shares one TRNG key generator among `N_REQ` consumers (crypto cores, boot ROM, software via a register bridge). It sits between the consumers and the TRNG top level. It drives the TRNG `enable` and `ack_read` inputs, captures each finished key, and delivers it to exactly one granted requester. It also handles TRNG total-failure interrupts and generation timeouts.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..16).
- `N_BITS_KEY`, 32: key width; must match the TRNG instance.
- `TIMEOUT_CYCLES`, 4096: maximum cycles spent in WAIT_KEY before abort; 0 disables the timeout.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_i`  in  N_REQ  level request per consumer; held high until its `valid_o` bit or `timeout_o` is seen.
- `gnt_o`  out  N_REQ  one-hot current grant; all-zero when no grant is active.
- `valid_o`  out  N_REQ  one-hot, single-cycle key delivery strobe.
- `key_o`  out  N_BITS_KEY  delivered key; valid only while any `valid_o` bit is high, zero otherwise.
- `timeout_o`  out  1  single-cycle pulse when the current grant is aborted by timeout.
- `fail_o`  out  1  sticky TRNG failure flag.
- `clear_fail_i`  in  1  single-cycle pulse that clears `fail_o` and leaves FAIL.
- `trng_enable_o`  out  1  drives the TRNG `enable` input.
- `trng_ack_read_o`  out  1  drives the TRNG `ack_read` input.
- `trng_key_ready_i`  in  1  from the TRNG `key_ready` output.
- `trng_key_i`  in  N_BITS_KEY  from the TRNG `out_key` output.
- `trng_intr_i`  in  1  from the TRNG `trng_intr` output (total failure).

## Operation
States: IDLE, WAIT_KEY, DELIVER, DRAIN, FAIL.

Arbitration:
- Round-robin pointer `last` (reset N_REQ-1).
- In IDLE, the winner is the first set bit of `req_i` searching from `last+1` with wrap-around.
- On a grant, `last` takes the winner index.

Per-state behaviour:
- IDLE
  - `trng_enable_o`=0.
  - If any `req_i` bit is high, register the winner into `gnt_o`, clear the timeout counter, and go to WAIT_KEY.
- WAIT_KEY
  - `trng_enable_o`=1 and the counter increments each cycle.
  - When `trng_key_ready_i`=1, `trng_ack_read_o`=1 combinationally in that same cycle and `trng_key_i` is captured into the key register at that edge.
    - If the granted `req_i` bit is still high, go to DELIVER.
    - Otherwise (requester withdrew), discard the key, clear `gnt_o`, and go to DRAIN.
  - If the counter reaches TIMEOUT_CYCLES (nonzero) without a key:
    - pulse `timeout_o` in the next cycle;
    - clear `gnt_o`;
    - go to IDLE with `trng_enable_o` low for at least one cycle, which restarts the TRNG.
- DELIVER
  - `trng_enable_o`=1.
  - The granted `valid_o` bit and `key_o`=captured key are driven for exactly one cycle.
  - Then clear `gnt_o` and go to DRAIN.
- DRAIN
  - `trng_enable_o`=1; wait until `trng_key_ready_i`=0, then go to IDLE.
  - This prevents the same key from being captured twice.
- FAIL
  - Entered from any state when `trng_intr_i`=1.
  - `trng_enable_o`=0, `gnt_o`=0, `fail_o`=1, and the key register is zeroed.
  - A pending DELIVER is cancelled and no `valid_o` is issued.
  - Stays in FAIL until `clear_fail_i`=1, then goes to IDLE.
  - If `trng_intr_i` is still high when `clear_fail_i` arrives, FAIL is re-entered next cycle.

Additional rules:
- `trng_intr_i` has priority over every other transition, including the key capture and timeout in the same cycle.
- The captured key is zeroed on leaving DELIVER; it is never observable outside the `valid_o` cycle.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and never wraps.

## Timing
- Reset values: state IDLE, `last`=N_REQ-1, and all outputs 0 (`gnt_o`, `valid_o`, `key_o`, `timeout_o`, `fail_o`, `trng_enable_o`, `trng_ack_read_o`); key register 0.
- Request to grant: `req_i` sampled high at edge t gives `gnt_o` and `trng_enable_o` high from t+1.
- Key to delivery: `trng_key_ready_i` high in cycle k gives `trng_ack_read_o` high in cycle k and `valid_o` in cycle k+1.
- Back-to-back requests: there is a minimum of one IDLE cycle between consecutive grants.
- A `req_i` bit changing while not granted has no effect until the next IDLE.

## Test plan
- Single request: `req_i`=4'b0001 and the TRNG returns key 32'hDEADBEEF after 100 cycles -> `gnt_o`=0001 from cycle 1; ack pulse in the key-ready cycle; `valid_o`=0001 with `key_o`=DEADBEEF one cycle later; back to IDLE once `trng_key_ready_i` falls.
- Fairness: all four `req_i` bits held high, 8 keys -> grant order 0,1,2,3,0,1,2,3, each requester receives a distinct key, and no `valid_o` is ever multi-hot.
- Withdrawal: requester 2 is granted and drops `req_i` before the key arrives -> the key is acked and discarded, no `valid_o`, and requester 3 is granted next.
- Timeout with TIMEOUT_CYCLES=16 and no key ready -> `timeout_o` pulses 17 cycles after the grant, `trng_enable_o` is low for at least 1 cycle, and the next requester is granted.
- Failure: `trng_intr_i` is asserted in the same cycle as `trng_key_ready_i` -> FAIL, no `valid_o`, `fail_o`=1 sticky; `clear_fail_i` with intr low -> IDLE and normal service resumes.
- Reset mid-operation: `rst_n` is asserted in DELIVER -> all outputs are 0 asynchronously and the first grant after reset goes to requester 0.
